// File: rtl/idu.sv
// RV32I instruction decode unit: valid/ready in, registered decode out, with a skid register for full throughput.
// Define IDU_MEXT_EN to decode OP with funct7=0000001 as a legal MULDIV instruction.
module idu #(
  parameter int XLEN = 32,
  parameter int PC_W = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            if_valid,
  output logic            if_ready,
  input  logic [PC_W-1:0] if_pc,
  input  logic [31:0]     if_instr,
  input  logic            flush,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [PC_W-1:0] id_pc,
  output logic [6:0]      id_opcode,
  output logic [4:0]      id_rd,
  output logic [4:0]      id_rs1,
  output logic [4:0]      id_rs2,
  output logic [2:0]      id_funct3,
  output logic [6:0]      id_funct7,
  output logic [XLEN-1:0] id_imm,
  output logic [3:0]      id_class,
  output logic            id_illegal
);

  typedef enum logic [3:0] {
    C_LUI     = 4'd0,
    C_AUIPC   = 4'd1,
    C_JAL     = 4'd2,
    C_JALR    = 4'd3,
    C_BRANCH  = 4'd4,
    C_LOAD    = 4'd5,
    C_STORE   = 4'd6,
    C_OP_IMM  = 4'd7,
    C_OP      = 4'd8,
    C_FENCE   = 4'd9,
    C_SYSTEM  = 4'd10,
    C_MULDIV  = 4'd11,
    C_ILLEGAL = 4'd15
  } cls_e;

  typedef enum logic [2:0] {
    IMM_NONE,
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J
  } imm_e;

  typedef struct packed {
    cls_e cls;
    imm_e ityp;
    logic ill;
  } dec_t;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MUL  = 7'b0000001;

  function automatic dec_t decode(input logic [31:0] w);
    dec_t       d;
    logic [2:0] f3;
    logic [6:0] f7;
    f3     = w[14:12];
    f7     = w[31:25];
    d.cls  = C_ILLEGAL;
    d.ityp = IMM_NONE;
    d.ill  = 1'b0;
    if (w[1:0] != 2'b11) begin
      d.ill = 1'b1;
    end else begin
      case (w[6:0])
        OPC_LUI:    begin d.cls = C_LUI;   d.ityp = IMM_U; end
        OPC_AUIPC:  begin d.cls = C_AUIPC; d.ityp = IMM_U; end
        OPC_JAL:    begin d.cls = C_JAL;   d.ityp = IMM_J; end
        OPC_JALR: begin
          d.cls  = C_JALR;
          d.ityp = IMM_I;
          d.ill  = (f3 != 3'b000);
        end
        OPC_BRANCH: begin
          d.cls  = C_BRANCH;
          d.ityp = IMM_B;
          d.ill  = (f3 == 3'b010) || (f3 == 3'b011);
        end
        OPC_LOAD: begin
          d.cls  = C_LOAD;
          d.ityp = IMM_I;
          d.ill  = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
        end
        OPC_STORE: begin
          d.cls  = C_STORE;
          d.ityp = IMM_S;
          d.ill  = (f3 >= 3'b011);
        end
        OPC_OP_IMM: begin
          d.cls  = C_OP_IMM;
          d.ityp = IMM_I;
          // Shift-immediates reuse the funct7 slot as an encoding qualifier
          if (f3 == 3'b001)
            d.ill = (f7 != F7_BASE);
          else if (f3 == 3'b101)
            d.ill = !((f7 == F7_BASE) || (f7 == F7_ALT));
        end
        OPC_OP: begin
          d.cls = C_OP;
          if (f7 == F7_MUL) begin
`ifdef IDU_MEXT_EN
            d.cls = C_MULDIV;
`else
            d.ill = 1'b1;
`endif
          end else begin
            d.ill = !((f7 == F7_BASE) ||
                      ((f7 == F7_ALT) && ((f3 == 3'b000) || (f3 == 3'b101))));
          end
        end
        OPC_FENCE:  d.cls = C_FENCE;
        OPC_SYSTEM: begin d.cls = C_SYSTEM; d.ityp = IMM_I; end
        default:    d.ill = 1'b1;
      endcase
    end
    if (d.ill) begin
      d.cls  = C_ILLEGAL;
      d.ityp = IMM_NONE;
    end
    return d;
  endfunction

  function automatic logic signed [XLEN-1:0] imm_gen(input imm_e t, input logic [31:0] w);
    logic signed [XLEN-1:0] r;
    case (t)
      IMM_I:   r = {{(XLEN-12){w[31]}}, w[31:20]};
      IMM_S:   r = {{(XLEN-12){w[31]}}, w[31:25], w[11:7]};
      IMM_B:   r = {{(XLEN-12){w[31]}}, w[7], w[30:25], w[11:8], 1'b0};
      IMM_U:   r = {{(XLEN-31){w[31]}}, w[30:12], 12'b0};
      IMM_J:   r = {{(XLEN-20){w[31]}}, w[19:12], w[20], w[30:21], 1'b0};
      default: r = '0;
    endcase
    return r;
  endfunction

  logic            vld_p0;
  logic            vld_p1;
  logic            rdy_q;
  logic [PC_W-1:0] pc_p0;
  logic [31:0]     instr_p0;

  logic            in_xfer;
  logic            out_xfer;
  logic            or_open;
  logic            or_take;
  logic            sk_take;
  logic            vld_p0_nxt;
  logic            vld_p1_nxt;
  logic [PC_W-1:0] sel_pc;
  logic [31:0]     sel_instr;
  dec_t            sel_dec;

  always_comb begin
    in_xfer    = if_valid & rdy_q;
    out_xfer   = vld_p1 & id_ready;
    or_open    = !vld_p1 | out_xfer;
    or_take    = or_open & (vld_p0 | in_xfer) & !flush;
    sk_take    = in_xfer & vld_p1 & !out_xfer & !flush;
    sel_pc     = vld_p0 ? pc_p0 : if_pc;
    sel_instr  = vld_p0 ? instr_p0 : if_instr;
    sel_dec    = decode(sel_instr);
    vld_p0_nxt = 1'b0;
    vld_p1_nxt = 1'b0;
    if (!flush) begin
      vld_p1_nxt = or_open ? (vld_p0 | in_xfer) : 1'b1;
      // The skid entry drains into the output register whenever that opens up
      vld_p0_nxt = sk_take | (vld_p0 & !or_open);
    end
  end

  // Control stage: occupancy of the skid (p0) and output (p1) registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
      rdy_q  <= 1'b0;
    end else begin
      vld_p0 <= vld_p0_nxt;
      vld_p1 <= vld_p1_nxt;
      rdy_q  <= !vld_p0_nxt;
    end
  end

  // Data stage: raw skid capture and decoded output register
  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_p0      <= '0;
      instr_p0   <= '0;
      id_pc      <= '0;
      id_opcode  <= '0;
      id_rd      <= '0;
      id_rs1     <= '0;
      id_rs2     <= '0;
      id_funct3  <= '0;
      id_funct7  <= '0;
      id_imm     <= '0;
      id_class   <= '0;
      id_illegal <= 1'b0;
    end else begin
      if (sk_take) begin
        pc_p0    <= if_pc;
        instr_p0 <= if_instr;
      end
      if (or_take) begin
        id_pc      <= sel_pc;
        id_opcode  <= sel_instr[6:0];
        id_rd      <= sel_instr[11:7];
        id_rs1     <= sel_instr[19:15];
        id_rs2     <= sel_instr[24:20];
        id_funct3  <= sel_instr[14:12];
        id_funct7  <= sel_instr[31:25];
        id_imm     <= imm_gen(sel_dec.ityp, sel_instr);
        id_class   <= sel_dec.cls;
        id_illegal <= sel_dec.ill;
      end
    end
  end

  assign id_valid = vld_p1;
  assign if_ready = rdy_q;

endmodule

// File: tb/tb_idu.sv
// Self-checking bench for idu: directed scenarios plus randomized traffic against a queue-based reference model.
module tb_idu;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        if_valid = 1'b0;
  logic        if_ready;
  logic [31:0] if_pc = '0;
  logic [31:0] if_instr = '0;
  logic        flush = 1'b0;
  logic        id_valid;
  logic        id_ready = 1'b0;
  logic [31:0] id_pc;
  logic [6:0]  id_opcode;
  logic [4:0]  id_rd;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic [2:0]  id_funct3;
  logic [6:0]  id_funct7;
  logic [31:0] id_imm;
  logic [3:0]  id_class;
  logic        id_illegal;

  int checks = 0;
  int errors = 0;
  logic [63:0] q[$];
  bit settled = 0;

  idu #(.XLEN(32), .PC_W(32)) dut (
    .clk(clk), .reset(reset), .if_valid(if_valid), .if_ready(if_ready),
    .if_pc(if_pc), .if_instr(if_instr), .flush(flush), .id_valid(id_valid),
    .id_ready(id_ready), .id_pc(id_pc), .id_opcode(id_opcode), .id_rd(id_rd),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_funct3(id_funct3), .id_funct7(id_funct7),
    .id_imm(id_imm), .id_class(id_class), .id_illegal(id_illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference decode from the ISA tables, immediates built by weighted bit sums
  function automatic void ref_decode(input logic [31:0] w, output logic [3:0] cls,
                                     output logic [31:0] imm, output logic il);
    int  s, t;
    int  f3, f7;
    byte k;
    s = w; f3 = w[14:12]; f7 = w[31:25];
    il = 1'b0; k = "N"; cls = 4'd15;
    case (w[6:0])
      7'h37: begin cls = 4'd0; k = "U"; end
      7'h17: begin cls = 4'd1; k = "U"; end
      7'h6F: begin cls = 4'd2; k = "J"; end
      7'h67: begin cls = 4'd3; k = "I"; il = (f3 != 0); end
      7'h63: begin cls = 4'd4; k = "B"; il = (f3 == 2 || f3 == 3); end
      7'h03: begin cls = 4'd5; k = "I"; il = (f3 == 3 || f3 == 6 || f3 == 7); end
      7'h23: begin cls = 4'd6; k = "S"; il = (f3 >= 3); end
      7'h13: begin
        cls = 4'd7; k = "I";
        if (f3 == 1) il = (f7 != 0);
        else if (f3 == 5) il = !(f7 == 0 || f7 == 32);
      end
      7'h33: begin
        cls = 4'd8;
        if (f7 == 1) begin
`ifdef IDU_MEXT_EN
          cls = 4'd11;
`else
          il = 1'b1;
`endif
        end else il = !(f7 == 0 || (f7 == 32 && (f3 == 0 || f3 == 5)));
      end
      7'h0F: cls = 4'd9;
      7'h73: begin cls = 4'd10; k = "I"; end
      default: il = 1'b1;
    endcase
    if (il) begin cls = 4'd15; k = "N"; end
    imm = 0;
    case (k)
      "I": begin t = s >>> 20; imm = t; end
      "S": begin t = s >>> 25; imm = t * 32 + ((w >> 7) & 31); end
      "B": begin
        t = s >>> 31;
        imm = t * 4096 + ((w >> 7) & 1) * 2048 + ((w >> 25) & 63) * 32 + ((w >> 8) & 15) * 2;
      end
      "U": imm = (w / 4096) * 4096;
      "J": begin
        t = s >>> 31;
        imm = t * 1048576 + ((w >> 12) & 255) * 4096 + ((w >> 20) & 1) * 2048 + ((w >> 21) & 1023) * 2;
      end
      default: imm = 0;
    endcase
  endfunction

  task automatic check_now();
    logic [31:0] w;
    logic [3:0]  c;
    logic [31:0] im;
    logic        il;
    chk("id_valid", {63'd0, id_valid}, {63'd0, q.size() > 0});
    if (settled) chk("if_ready", {63'd0, if_ready}, {63'd0, q.size() < 2});
    if (q.size() > 0) begin
      w = q[0][31:0];
      ref_decode(w, c, im, il);
      chk("fields", {id_pc, id_opcode, id_rd, id_rs1, id_rs2, id_funct3, id_funct7},
          {q[0][63:32], w[6:0], w[11:7], w[19:15], w[24:20], w[14:12], w[31:25]});
      chk("imm", {32'd0, id_imm}, {32'd0, im});
      chk("class", {59'd0, id_class, id_illegal}, {59'd0, c, il});
    end
  endtask

  // One clock: drive, check at negedge, advance model on posedge, return #1 after it
  task automatic step(input bit v, input logic [31:0] ins, input logic [31:0] pc,
                      input bit rdy, input bit fl);
    bit in_x, out_x;
    if_valid = v; if_instr = ins; if_pc = pc; id_ready = rdy; flush = fl;
    @(negedge clk);
    check_now();
    in_x  = settled && v && (q.size() < 2);
    out_x = (q.size() > 0) && rdy;
    @(posedge clk);
    settled = reset;
    if (!reset || fl) q.delete();
    else begin
      if (out_x) void'(q.pop_front());
      if (in_x) q.push_back({pc, ins});
    end
    #1;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0]  ops[11];
    logic [6:0]  f7;
    logic [31:0] r;
    int          i;
    ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0F, 7'h73};
    r = $urandom;
    i = $urandom_range(0, 11);
    if (i == 11) return r;
    case ($urandom_range(0, 3))
      0: f7 = 7'h00;
      1: f7 = 7'h20;
      2: f7 = 7'h01;
      default: f7 = r[31:25];
    endcase
    return {f7, r[24:7], ops[i]};
  endfunction

  initial begin
    logic [31:0] pcr;
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("rst_ctl", {58'd0, id_valid, id_class, id_illegal}, 64'd0);
    chk("rst_fields", {id_pc, id_opcode, id_rd, id_rs1, id_rs2, id_funct3, id_funct7}, 64'd0);
    reset = 1'b1;
    step(0, 0, 0, 0, 0);
    chk("rdy_after_rst", {63'd0, if_ready}, 64'd1);

    step(1, 32'h00500093, 32'h100, 1, 0);
    chk("addi_vld", {63'd0, id_valid}, 64'd1);
    chk("addi_cls", {51'd0, id_class, id_rd, id_rs1}, {51'd0, 4'd7, 5'd1, 5'd0});
    chk("addi_imm", {31'd0, id_imm, id_illegal}, {31'd0, 32'h5, 1'b0});
    step(1, 32'hFE000EE3, 32'h104, 1, 0);
    chk("beq", {29'd0, id_class, id_funct3, id_imm}, {29'd0, 4'd4, 3'd0, 32'hFFFFFFFC});
    step(1, 32'h123452B7, 32'h108, 1, 0);
    chk("lui", {27'd0, id_class, id_rd, id_imm}, {27'd0, 4'd0, 5'd5, 32'h12345000});
    step(1, 32'h022081B3, 32'h10C, 1, 0);
`ifdef IDU_MEXT_EN
    chk("mul", {59'd0, id_class, id_illegal}, {59'd0, 4'd11, 1'b0});
`else
    chk("mul", {27'd0, id_class, id_illegal, id_imm}, {27'd0, 4'd15, 1'b1, 32'd0});
`endif
    step(1, 32'h00000000, 32'h110, 1, 0);
    chk("zero_word", {59'd0, id_class, id_illegal}, {59'd0, 4'd15, 1'b1});
    step(0, 0, 0, 1, 0);

    step(1, 32'h00100113, 32'h0, 0, 0);
    step(1, 32'h00200193, 32'h4, 0, 0);
    step(1, 32'h00300213, 32'h8, 0, 0);
    chk("bp_hold", {31'd0, if_ready, id_pc}, {31'd0, 1'b0, 32'h0});
    step(1, 32'h00300213, 32'h8, 1, 0);
    chk("bp_pc4", {32'd0, id_pc}, 64'h4);
    step(1, 32'h00300213, 32'h8, 1, 0);
    chk("bp_pc8", {31'd0, id_valid, id_pc}, {31'd0, 1'b1, 32'h8});
    step(0, 0, 0, 1, 0);

    step(1, 32'h00100113, 32'h20, 0, 0);
    step(1, 32'h00200193, 32'h24, 0, 0);
    chk("full_rdy", {63'd0, if_ready}, 64'd0);
    step(1, 32'h00300213, 32'h28, 0, 1);
    chk("flush_full", {62'd0, id_valid, if_ready}, {62'd0, 2'b01});
    step(1, 32'h00100113, 32'h30, 0, 0);
    step(1, 32'h00200193, 32'h34, 0, 1);
    chk("flush_in", {62'd0, id_valid, if_ready}, {62'd0, 2'b01});
    step(0, 0, 0, 1, 0);
    chk("flush_nocap", {63'd0, id_valid}, 64'd0);

    step(1, 32'h00500093, 32'h40, 0, 0);
    chk("pre_rst", {63'd0, id_valid}, 64'd1);
    reset = 1'b0;
    step(1, 32'h123452B7, 32'h44, 1, 0);
    chk("mid_rst_ctl", {58'd0, id_valid, id_class, id_illegal}, 64'd0);
    chk("mid_rst_fields", {id_pc, id_opcode, id_rd, id_rs1, id_rs2, id_funct3, id_funct7}, 64'd0);
    chk("mid_rst_imm", {32'd0, id_imm}, 64'd0);
    reset = 1'b1;
    step(0, 0, 0, 1, 0);
    chk("rdy_release", {62'd0, if_ready, id_valid}, {62'd0, 2'b10});

    pcr = 32'h1000;
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 3) != 0, rand_instr(), pcr, $urandom_range(0, 3) != 0,
           $urandom_range(0, 31) == 0);
      pcr += 4;
    end
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/idu.md
# idu

Instruction decode unit for the RV32I core. It sits directly downstream of the IFU and accepts the fetched instruction word and its PC over a valid/ready handshake. It decodes the word into register indices, function fields, a sign-extended immediate and an instruction class, and presents the result to the execute stage through a registered valid/ready output. A two-entry elastic buffer (output register plus skid register) gives full throughput under backpressure, and a flush input discards in-flight instructions on redirects.

## Interface
- XLEN, 32, data/immediate width
- PC_W, 32, program counter width

- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset
- if_valid  in  1  IFU presents an instruction
- if_ready  out  1  IDU can accept
- if_pc  in  PC_W  PC of presented instruction
- if_instr  in  32  raw instruction word
- flush  in  1  discard all buffered instructions
- id_valid  out  1  decoded instruction available
- id_ready  in  1  execute stage accepts
- id_pc  out  PC_W  PC of decoded instruction
- id_opcode  out  7  instr[6:0]
- id_rd / id_rs1 / id_rs2  out  5 each  instr[11:7] / [19:15] / [24:20]
- id_funct3  out  3  instr[14:12]
- id_funct7  out  7  instr[31:25]
- id_imm  out  XLEN  sign-extended immediate
- id_class  out  4  0 LUI, 1 AUIPC, 2 JAL, 3 JALR, 4 BRANCH, 5 LOAD, 6 STORE, 7 OP_IMM, 8 OP, 9 FENCE, 10 SYSTEM, 11 MULDIV, 15 ILLEGAL
- id_illegal  out  1  instruction is not legal

## Operation
- State: output register OR (decoded fields plus valid), skid register SK (raw pc/instr plus sk_valid).
- Input transfer: if_valid & if_ready. Output transfer: id_valid & id_ready.
- if_ready = !sk_valid. It is a register-driven signal with no combinational path from id_ready.
- OR loads when it is empty or an output transfer occurs. The source is SK if sk_valid, otherwise the input on an input transfer. If neither applies, OR empties.
- SK loads the input on an input transfer while OR is occupied and there is no output transfer. SK empties when OR loads from it.
- Order is strictly FIFO. No instruction is dropped or duplicated.
- Decode is combinational on the word being loaded into OR. All id_* outputs are registered.
- Immediate types:
  - I: LOAD, OP_IMM, JALR, SYSTEM.
  - S: STORE.
  - B: BRANCH, bit 0 = 0.
  - U: LUI, AUIPC, low 12 bits = 0.
  - J: JAL, bit 0 = 0.
  - All other types, including ILLEGAL: imm = 0.
- Illegal conditions:
  - instr[1:0] != 2'b11, or unknown opcode.
  - BRANCH funct3 ∈ {010, 011}.
  - LOAD funct3 ∈ {011, 110, 111}.
  - STORE funct3 ≥ 011.
  - JALR funct3 != 000.
  - OP funct7 other than 0000000, or 0100000 with funct3 ∈ {000, 101}.
  - OP_IMM shift (funct3 001/101) with funct7 other than 0000000, or 0100000 with funct3 101.
- An illegal instruction still flows through: id_illegal = 1, id_class = 15, field outputs decoded as normal, imm = 0.

## Timing
- Latency 1 cycle: an input transfer at edge N into an empty IDU gives id_valid = 1 after edge N.
- Throughput is 1 instruction/cycle while id_ready = 1.
- id_ready low: the first instruction holds in OR and the second goes into SK. if_ready then drops in the cycle after SK fills.
- id_valid and the id_* fields are stable while id_valid & !id_ready.
- flush has highest priority: OR valid and SK valid both clear at the next edge, and any simultaneous input is ignored. An output transfer in the flush cycle still counts as consumed. if_ready = 1 after the flush edge.
- Reset (reset = 0 at an edge): all outputs are 0, except if_ready, which is 1 from the first cycle after reset is released. if_valid is ignored while reset = 0. Reset mid-operation discards OR and SK contents.
- On a flush or when emptying, data fields keep their last values. Only the valid signals clear.

## Configuration
- IDU_MEXT_EN defined: OP with funct7 = 0000001 (any funct3) decodes as class 11 MULDIV, legal.
- IDU_MEXT_EN undefined: that encoding is ILLEGAL (class 15, id_illegal = 1).

## Test plan
- Input 0x00500093 (addi x1,x0,5) with id_ready = 1 → one cycle later: class 7, rd = 1, rs1 = 0, imm = 0x00000005, illegal = 0.
- Input 0xFE000EE3 (beq x0,x0,-4) → class 4, funct3 = 0, imm = 0xFFFFFFFC. Input 0x123452B7 (lui x5,0x12345) → class 0, rd = 5, imm = 0x12345000.
- Input 0x022081B3 (mul x3,x1,x2) → with IDU_MEXT_EN: class 11, illegal = 0. Without it: class 15, illegal = 1, imm = 0.
- id_ready = 0 while three back-to-back instructions (PCs 0x0, 0x4, 0x8) are presented → OR holds 0x0, SK holds 0x4, if_ready = 0, and 0x8 is held at the IFU. Release id_ready → outputs in order 0x0, 0x4, 0x8 on consecutive cycles.
- OR and SK both full, then flush = 1 for one cycle together with if_valid = 1 → id_valid = 0 and if_ready = 1 next cycle, and the flush-cycle input is not captured.
- reset = 0 mid-stream with id_valid = 1 → next cycle all outputs are 0 and if_ready = 1 after release. Input 0x00000000 → class 15, illegal = 1.
